// File: rtl/mux_arb_n_to_1_pkg.sv
// Shared constants and helpers for the M-to-1 arbitrated output mux.
package mux_arb_n_to_1_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Ceiling log2 for callers sizing SEL_W from M
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_n_to_1_rr_arbiter.sv
// Combinational round-robin arbiter: first request after last_grant, modulo M.
module rr_arbiter #(
  parameter int unsigned M     = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic [M-1:0]     req,
  input  logic [SEL_W-1:0] last_grant,
  output logic [SEL_W-1:0] grant,
  output logic             grant_valid
);

  int unsigned sh;
  int unsigned off;
  logic [M-1:0] rot;

  // Rotate so the channel after last_grant sits at bit 0, then take the lowest set bit
  always_comb begin
    sh          = (32'(last_grant) + 32'd1) % M;
    rot         = M'({req, req} >> sh);
    off         = 0;
    grant_valid = 1'b0;
    for (int k = 0; k < int'(M); k++) begin
      if (!grant_valid && rot[k]) begin
        grant_valid = 1'b1;
        off         = 32'(k);
      end
    end
    grant = SEL_W'((sh + off) % M);
  end

endmodule

// File: rtl/mux_arb_n_to_1.sv
// M-input registered output mux with valid/ready handshake, explicit or round-robin select.
module mux_arb_n_to_1
  import mux_arb_n_to_1_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned M     = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             mode,
  input  logic [SEL_W-1:0] selector,
  input  logic [M*N-1:0]   in_data,
  input  logic [M-1:0]     in_valid,
  output logic [M-1:0]     in_ready,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_chan
);

  logic [SEL_W-1:0] last_grant;
  logic [SEL_W-1:0] rr_g_c;
  logic             rr_gv_c;
  logic             sel_gv_c;
  logic [SEL_W-1:0] g_c;
  logic             gv_c;
  logic             load_c;
  logic [N-1:0]     g_data_c;

  rr_arbiter #(.M(M), .SEL_W(SEL_W)) u_rr (
    .req         (in_valid),
    .last_grant  (last_grant),
    .grant       (rr_g_c),
    .grant_valid (rr_gv_c)
  );

  // Explicit select: selectors at or beyond M match no channel and so never grant
  always_comb begin
    sel_gv_c = 1'b0;
    for (int k = 0; k < int'(M); k++) begin
      if (selector == SEL_W'(k) && in_valid[k]) sel_gv_c = 1'b1;
    end
  end

  // Grant steering, accept strobes and selected data
  always_comb begin
    g_c      = (mode == MODE_RR) ? rr_g_c : selector;
    gv_c     = (mode == MODE_RR) ? rr_gv_c : sel_gv_c;
    load_c   = !out_valid || out_ready;
    in_ready = '0;
    g_data_c = '0;
    for (int k = 0; k < int'(M); k++) begin
      if (g_c == SEL_W'(k)) begin
        g_data_c    = in_data[k*N +: N];
        in_ready[k] = rstb && load_c && gv_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      last_grant <= SEL_W'(M - 1);
    end else if (load_c) begin
      out_valid <= gv_c;
      if (gv_c) begin
        out_data <= g_data_c;
        out_chan <= g_c;
        if (mode == MODE_RR) last_grant <= g_c;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_n_to_1.sv
// Directed bench for mux_arb_n_to_1 with a per-cycle reference model and literal spot checks.
module tb_mux_arb_n_to_1;

  localparam int unsigned N     = 32;
  localparam int unsigned M     = 8;
  localparam int unsigned SEL_W = 3;

  logic             clk = 1'b0;
  logic             rstb;
  logic             mode;
  logic [SEL_W-1:0] selector;
  logic [M*N-1:0]   in_data;
  logic [M-1:0]     in_valid;
  logic [M-1:0]     in_ready;
  logic [N-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] out_chan;

  logic [N-1:0] ch_data [M];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // reference state
  bit          m_valid = 1'b0;
  logic [N-1:0] m_data = '0;
  int          m_chan  = 0;
  int          m_ptr   = M - 1;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < int'(M); k++) in_data[k*N +: N] = ch_data[k];
  end

  mux_arb_n_to_1 #(.N(N), .M(M), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .mode      (mode),
    .selector  (selector),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Which channel the rules pick right now, from the model pointer
  task automatic model_grant(output bit found, output int ch);
    found = 1'b0;
    ch    = 0;
    if (mode == 1'b0) begin
      if (int'(selector) < int'(M) && in_valid[selector]) begin
        found = 1'b1;
        ch    = int'(selector);
      end
    end else begin
      for (int off = 1; off <= int'(M); off++) begin
        int c;
        c = (m_ptr + off) % int'(M);
        if (!found && in_valid[c]) begin
          found = 1'b1;
          ch    = c;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_chan  = 0;
      m_ptr   = M - 1;
    end else if (!m_valid || out_ready) begin
      bit f;
      int g;
      model_grant(f, g);
      m_valid = f;
      if (f) begin
        m_data = ch_data[g];
        m_chan = g;
        if (mode) m_ptr = g;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit f;
      int g;
      logic [M-1:0] exp_rdy;
      model_grant(f, g);
      exp_rdy = '0;
      if (rstb && (!m_valid || out_ready) && f) exp_rdy[g] = 1'b1;
      chk("model in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("model out_valid", 32'(out_valid), 32'(m_valid));
      chk("model out_data", out_data, m_data);
      chk("model out_chan", 32'(out_chan), 32'(m_chan));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstb      = 1'b1;
    mode      = 1'b1;
    selector  = '0;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    for (int k = 0; k < int'(M); k++) ch_data[k] = 32'(k);
    #1 rstb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset out_chan", 32'(out_chan), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk_en = 1'b1;

    // release in round-robin with all channels requesting
    rstb = 1'b1;
    #1 chk("rr first in_ready", 32'(in_ready), 32'h01);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("rr fair chan", 32'(out_chan), 32'(i % 8));
      chk("rr fair data", out_data, 32'(i % 8));
      chk("rr fair valid", 32'(out_valid), 32'd1);
    end

    // explicit select of channel 5
    mode       = 1'b0;
    selector   = 3'd5;
    in_valid   = 8'h20;
    ch_data[5] = 32'hDEADBEEF;
    #1 chk("sel in_ready", 32'(in_ready), 32'h20);
    step();
    chk("sel data", out_data, 32'hDEADBEEF);
    chk("sel chan", 32'(out_chan), 32'd5);
    chk("sel valid", 32'(out_valid), 32'd1);

    // selected channel not requesting
    selector = 3'd2;
    in_valid = 8'h01;
    #1 chk("sel idle in_ready", 32'(in_ready), 32'd0);
    step();
    chk("sel idle valid", 32'(out_valid), 32'd0);
    chk("sel idle data hold", out_data, 32'hDEADBEEF);

    // backpressure holds the entry
    selector   = 3'd3;
    in_valid   = 8'h08;
    ch_data[3] = 32'h1234;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      selector = SEL_W'(i + 4);
      in_valid = 8'hFF >> i;
      #1 chk("bp in_ready", 32'(in_ready), 32'd0);
      step();
      chk("bp data", out_data, 32'h1234);
      chk("bp chan", 32'(out_chan), 32'd3);
      chk("bp valid", 32'(out_valid), 32'd1);
    end
    out_ready  = 1'b1;
    selector   = 3'd6;
    in_valid   = 8'h40;
    ch_data[6] = 32'h6666_0006;
    #1 chk("bp release in_ready", 32'(in_ready), 32'h40);
    step();
    chk("bp release data", out_data, 32'h6666_0006);
    chk("bp release chan", 32'(out_chan), 32'd6);
    chk("bp release valid", 32'(out_valid), 32'd1);

    // sparse round-robin: pointer still at channel 0
    mode     = 1'b1;
    in_valid = 8'b1000_0010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sparse chan", 32'(out_chan), (i % 2 == 0) ? 32'd1 : 32'd7);
      chk("sparse data", out_data, (i % 2 == 0) ? 32'd1 : 32'd7);
    end

    // asynchronous reset mid-cycle
    #2 rstb = 1'b0;
    #1;
    chk("async rst valid", 32'(out_valid), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd0);
    step();
    rstb = 1'b1;
    #1 chk("post rst in_ready", 32'(in_ready), 32'h02);
    step();
    chk("post rst chan", 32'(out_chan), 32'd1);
    chk("post rst valid", 32'(out_valid), 32'd1);

    in_valid = '0;
    step();
    chk("drain valid", 32'(out_valid), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
